// File: rtl/attn_score_prep.sv
// attn_score_prep: scales, rounds and saturates one row of Q.K accumulators
// to Q8.7, applies the optional causal mask and streams the row to softmax.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a row (sampled only in IDLE)
//   qpos_i, causal_i      query position / mask enable, latched on start
//   in_valid_i/in_ready_o accumulator input handshake, in_data_i signed ACC_W
//   sm_start_o            one-cycle start pulse to softmax
//   out_valid_o/out_ready_i score output handshake, out_data_o signed Q8.7
//   done_o                one-cycle pulse after the last output handshake
module attn_score_prep #(
  parameter int N        = 256,
  parameter int ACC_W    = 32,
  parameter int ACC_FRAC = 14,
  parameter int FRAC_W   = 7,
  parameter int SHIFT    = 3,
  parameter int OUT_W    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [$clog2(N)-1:0]    qpos_i,
  input  logic                    causal_i,
  input  logic                    in_valid_i,
  input  logic [ACC_W-1:0]        in_data_i,
  output logic                    in_ready_o,
  output logic                    sm_start_o,
  output logic                    out_valid_o,
  output logic [OUT_W-1:0]        out_data_o,
  input  logic                    out_ready_i,
  output logic                    done_o
);

  localparam int IDX_W = $clog2(N);
  localparam int SH    = ACC_FRAC - FRAC_W + SHIFT;
  localparam int EXT_W = ACC_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic signed [EXT_W-1:0] RND =
    EXT_W'(2 ** (SH - 1));
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    EXT_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    -SAT_MAX;

  // Most negative code is kept exclusively for masked positions.
  localparam logic [OUT_W-1:0] MASK_CODE =
    {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  qpos_q, qpos_d;
  logic              causal_q, causal_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              sm_start_q, sm_start_d;
  logic              done_q, done_d;

  logic                    in_ready;
  logic                    accept;
  logic                    out_hs;
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;
  logic [OUT_W-1:0]        sat;
  logic                    masked;
  logic [OUT_W-1:0]        score;

  // Score datapath: one extra bit keeps the rounding add from wrapping.
  always_comb begin
    ext     = {in_data_i[ACC_W-1], in_data_i};
    rounded = ext + RND;
    shifted = rounded >>> SH;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end else begin
      sat = shifted[OUT_W-1:0];
    end
    masked = causal_q && (idx_q > qpos_q);
    score  = masked ? MASK_CODE : sat;
  end

  // Control and output register next state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    qpos_d      = qpos_q;
    causal_d    = causal_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sm_start_d  = 1'b0;
    done_d      = 1'b0;

    // The output register frees up in the same cycle it is drained.
    in_ready = (state_q == S_RUN)
            && (out_ready_i || !out_valid_q);
    accept   = in_ready && in_valid_i;
    out_hs   = out_valid_q && out_ready_i;

    if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = score;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_START;
          qpos_d     = qpos_i;
          causal_d   = causal_i;
          idx_d      = '0;
          sm_start_d = 1'b1;
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Last element sits in the output register here.
        if (out_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      qpos_q      <= '0;
      causal_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sm_start_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      qpos_q      <= qpos_d;
      causal_q    <= causal_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sm_start_q  <= sm_start_d;
      done_q      <= done_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign sm_start_o  = sm_start_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_attn_score_prep.sv
// tb_attn_score_prep: randomized self-checking bench for attn_score_prep
// against a plain-arithmetic reference model of the score rules.
module tb_attn_score_prep;

  localparam int N     = 256;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int IDX_W = $clog2(N);

  logic               clk = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic [IDX_W-1:0]   qpos_i;
  logic               causal_i;
  logic               in_valid_i;
  logic [ACC_W-1:0]   in_data_i;
  logic               in_ready_o;
  logic               sm_start_o;
  logic               out_valid_o;
  logic [OUT_W-1:0]   out_data_o;
  logic               out_ready_i;
  logic               done_o;

  int checks = 0;
  int errors = 0;

  int acc_a [N];
  logic [OUT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  attn_score_prep dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .qpos_i      (qpos_i),
    .causal_i    (causal_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .sm_start_o  (sm_start_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .done_o      (done_o)
  );

  // Reference: scale by 2^-10 with round-half-up, clamp to +-32767,
  // masked positions become -32768.
  function automatic logic [OUT_W-1:0] model(
    input int acc, input int idx, input int qpos, input bit causal
  );
    longint v;
    longint q;
    if (causal && idx > qpos) return 16'h8000;
    v = longint'(acc) + 512;
    q = v / 1024;
    if (v < 0 && (v % 1024) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32767) q = -32767;
    return q[OUT_W-1:0];
  endfunction

  // Runs one row; returns early after stop_after accepted inputs.
  // vmode: 0 valid always, 1 random. rmode: 0 ready always,
  // 1 toggling, 2 random. glitch: cycle to pulse start_i (-1 none).
  task automatic run_row(
    input int qpos, input bit causal, input int vmode,
    input int rmode, input int stop_after, input int glitch
  );
    int sent = 0;
    int rcvd = 0;
    int cyc = 2;
    int first_e = -1;
    int last_e = -1;
    bit hold_pend = 0;
    logic [OUT_W-1:0] hold_val = '0;
    logic [OUT_W-1:0] e;
    bit ok = 0;
    exp_q.delete();
    start_i = 1'b1;
    qpos_i = IDX_W'(qpos);
    causal_i = causal;
    in_valid_i = 1'b1;
    in_data_i = 32'h7FFF_FFFF;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    qpos_i = IDX_W'($urandom);
    causal_i = 1'($urandom);
    checks++;
    if (sm_start_o !== 1'b1 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL start_cycle: sm_start=%b in_ready=%b, want 1 0",
               sm_start_o, in_ready_o);
    end
    @(posedge clk); #1;
    while (cyc < 20 * N) begin
      in_valid_i = (vmode == 0) ? 1'b1 : 1'($urandom);
      in_data_i = acc_a[(sent < N) ? sent : 0];
      case (rmode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = cyc[0];
        default: out_ready_i = 1'($urandom);
      endcase
      start_i = (cyc == glitch);
      #1;
      checks++;
      if (sm_start_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL run_pulses: sm_start=%b done=%b, want 0 0",
                 sm_start_o, done_o);
      end
      checks++;
      if (out_valid_o !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b want %b",
                 out_valid_o, exp_q.size() != 0);
      end
      checks++;
      if (in_ready_o !==
          ((sent < N) && (out_ready_i || !out_valid_o))) begin
        errors++;
        $display("FAIL in_ready: got %b sent=%0d ordy=%b oval=%b",
                 in_ready_o, sent, out_ready_i, out_valid_o);
      end
      if (hold_pend) begin
        checks++;
        if (out_data_o !== hold_val) begin
          errors++;
          $display("FAIL hold: got %h want %h", out_data_o, hold_val);
        end
      end
      if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_data_o !== e) begin
          errors++;
          $display("FAIL score[%0d]: got %0d want %0d", rcvd,
                   $signed(out_data_o), $signed(e));
        end
        rcvd++;
      end
      hold_pend = out_valid_o && !out_ready_i;
      hold_val = out_data_o;
      if (in_valid_i && in_ready_o && sent < N) begin
        exp_q.push_back(model(acc_a[sent], sent, qpos, causal));
        if (first_e < 0) first_e = cyc;
        last_e = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      start_i = 1'b0;
      if (stop_after < N && sent == stop_after) return;
      if (rcvd == N) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL row_timeout: rcvd=%0d want %0d", rcvd, N);
      return;
    end
    checks++;
    if (done_o !== 1'b1 || out_valid_o !== 1'b0 ||
        in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b oval=%b irdy=%b want 1 0 0",
               done_o, out_valid_o, in_ready_o);
    end
    if (vmode == 0 && rmode == 0) begin
      checks++;
      if (first_e != 2 || last_e - first_e != N - 1) begin
        errors++;
        $display("FAIL throughput: first=%0d span=%0d want 2 %0d",
                 first_e, last_e - first_e, N - 1);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_once: got %b want 0", done_o);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    checks++;
    if (in_ready_o !== 1'b0 || sm_start_o !== 1'b0 ||
        out_valid_o !== 1'b0 || out_data_o !== '0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: ir=%b ss=%b ov=%b od=%h dn=%b want all 0",
               nm, in_ready_o, sm_start_o, out_valid_o,
               out_data_o, done_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    start_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    qpos_i = '0;
    causal_i = 1'b0;
    in_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_outs("reset_state");
    @(posedge clk); #1;
    check_reset_outs("idle_state");
  endtask

  task automatic test_rounding;
    for (int i = 0; i < N; i++) acc_a[i] = int'($urandom);
    acc_a[0] = 12800 * 1024;
    acc_a[1] = 511;
    acc_a[2] = 512;
    acc_a[3] = -512;
    acc_a[4] = -513;
    acc_a[5] = 1535;
    acc_a[6] = -1537;
    run_row(0, 1'b0, 0, 0, N, -1);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < N; i++) acc_a[i] = int'($urandom);
    acc_a[0] = 32'h7FFF_FFFF;
    acc_a[1] = 32'h8000_0000;
    acc_a[2] = 32767 * 1024 + 511;
    acc_a[3] = 32767 * 1024 + 512;
    acc_a[4] = -32767 * 1024 - 512;
    acc_a[5] = -32767 * 1024 - 513;
    run_row(N - 1, 1'b0, 1, 2, N, -1);
  endtask

  task automatic test_causal;
    for (int i = 0; i < N; i++) acc_a[i] = 0;
    run_row(42, 1'b1, 0, 0, N, -1);
    for (int i = 0; i < N; i++) acc_a[i] = int'($urandom);
    run_row(N - 1, 1'b1, 1, 2, N, -1);
    run_row(0, 1'b1, 0, 2, N, -1);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < N; i++) acc_a[i] = i * 1024;
    run_row(0, 1'b0, 0, 1, N, -1);
  endtask

  task automatic test_start_ignored;
    for (int i = 0; i < N; i++) acc_a[i] = int'($urandom) >>> 8;
    run_row(100, 1'b1, 0, 0, N, 50);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) acc_a[i] = int'($urandom);
      run_row(int'($urandom_range(0, N - 1)), 1'($urandom),
              1, 2, N, int'($urandom_range(3, 200)));
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < N; i++) acc_a[i] = i * 1024 - 50000;
    run_row(10, 1'b1, 0, 2, 100, -1);
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_reset_outs("reset_mid_row");
    run_row(200, 1'b1, 1, 2, N, -1);
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_causal();
    test_backpressure();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
